// File: rtl/dpram_arb_pkg.sv
// Shared encodings for the dual-port RAM port arbiter: access sizes, sequencer
// states and the helpers that turn an access size into a byte count or data mask.
package dpram_arb_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;
    localparam logic [1:0] SZ_RSVD = 2'd3;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_READ  = 2'd1,
        ARB_WRITE = 2'd2
    } arb_state_t;

    function automatic logic [2:0] bytes_of(input logic [1:0] size);
        case (size)
            SZ_BYTE: bytes_of = 3'd1;
            SZ_HALF: bytes_of = 3'd2;
            default: bytes_of = 3'd4;
        endcase
    endfunction

    function automatic logic [31:0] size_mask(input logic [1:0] size);
        case (size)
            SZ_BYTE: size_mask = 32'h0000_00ff;
            SZ_HALF: size_mask = 32'h0000_ffff;
            default: size_mask = 32'hffff_ffff;
        endcase
    endfunction

endpackage

// File: rtl/dpram_port_arbiter_rr.sv
// Combinational round-robin pick: the first set request at or after ptr, with wrap.
// The pointer register itself lives in the parent.
module rr_arbiter #(
    parameter int NREQ  = 3,
    parameter int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0]  req,
    input  logic [PTR_W-1:0] ptr,
    output logic             any,
    output logic [PTR_W-1:0] grant
);

    localparam int SUM_W = PTR_W + 1;

    logic [SUM_W-1:0] idx;

    // Scan farthest-first so the candidate closest to ptr is assigned last and wins.
    always_comb begin
        any   = 1'b0;
        grant = '0;
        idx   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = {1'b0, ptr} + SUM_W'(k);
            if (idx >= SUM_W'(NREQ)) idx = idx - SUM_W'(NREQ);
            if (req[idx[PTR_W-1:0]]) begin
                any   = 1'b1;
                grant = idx[PTR_W-1:0];
            end
        end
    end

endmodule

// File: rtl/dpram_port_arbiter.sv
// Shares one word-wide RAM port among NREQ requesters with round-robin grants;
// sub-word writes become read-modify-write, out-of-window accesses are rejected.
module dpram_port_arbiter
    import dpram_arb_pkg::*;
#(
    parameter int NREQ   = 3,
    parameter int ADDR_W = 16
) (
    input  logic                m_clock,
    input  logic                p_reset,
    input  logic [NREQ-1:0]     req,
    input  logic [NREQ-1:0]     req_we,
    input  logic [2*NREQ-1:0]   req_size,
    input  logic [32*NREQ-1:0]  req_addr,
    input  logic [32*NREQ-1:0]  req_wdata,
    output logic [NREQ-1:0]     ack,
    output logic [31:0]         rdata,
    output logic                err,
    output logic [31:0]         mem_addr,
    output logic [31:0]         mem_wdata,
    output logic                mem_we,
    input  logic [31:0]         mem_rdata,
    output arb_state_t          dbg_state
);

    // Handshake: a requester raises req with its command fields stable and keeps
    // them until ack; ack is a one-cycle pulse to the granted requester only.
    // The command is latched at grant, so dropping req early does not cancel it.

    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [32:0] LIMIT     = 33'd1 << ADDR_W;
    localparam logic [31:0] ADDR_MASK = 32'(LIMIT - 33'd1);

    arb_state_t       state, state_nx;
    logic [PTR_W-1:0] rr_ptr, grant, owner;
    logic             any;
    logic             l_we, l_bad;
    logic [1:0]       l_size;
    logic [31:0]      l_addr, l_wdata, merged, merge_val;

    logic             sel_we, sel_bad;
    logic [1:0]       sel_size;
    logic [31:0]      sel_addr, sel_wdata;
    logic [32:0]      end_addr;

    rr_arbiter #(.NREQ(NREQ), .PTR_W(PTR_W)) u_rr (
        .req   (req),
        .ptr   (rr_ptr),
        .any   (any),
        .grant (grant)
    );

    always_comb begin
        sel_we    = 1'b0;
        sel_size  = SZ_BYTE;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant == PTR_W'(i)) begin
                sel_we    = req_we[i];
                sel_size  = req_size[2*i +: 2];
                sel_addr  = req_addr[32*i +: 32];
                sel_wdata = req_wdata[32*i +: 32];
            end
        end
        // 33-bit sum so an address near 2^32 cannot wrap back into the window.
        end_addr = {1'b0, sel_addr} + {30'd0, bytes_of(sel_size)};
        sel_bad  = (sel_size == SZ_RSVD) || (end_addr > LIMIT);
    end

    always_ff @(posedge m_clock) begin
        if (p_reset) begin
            state   <= ARB_IDLE;
            rr_ptr  <= '0;
            owner   <= '0;
            l_we    <= 1'b0;
            l_bad   <= 1'b0;
            l_size  <= SZ_BYTE;
            l_addr  <= '0;
            l_wdata <= '0;
            merged  <= '0;
        end else begin
            state <= state_nx;
            if (state == ARB_IDLE && any) begin
                owner   <= grant;
                l_we    <= sel_we;
                l_bad   <= sel_bad;
                l_size  <= sel_size;
                l_addr  <= sel_addr;
                l_wdata <= sel_wdata;
                rr_ptr  <= (grant == PTR_W'(NREQ - 1)) ? '0 : grant + PTR_W'(1);
            end
            if (state == ARB_READ) merged <= merge_val;
        end
    end

    always_comb begin
        state_nx  = state;
        ack       = '0;
        err       = 1'b0;
        rdata     = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
        merge_val = l_wdata;
        case (state)
            ARB_IDLE: begin
                if (any) state_nx = ARB_READ;
            end
            ARB_READ: begin
                mem_addr = l_addr & ADDR_MASK;
                if (l_bad) begin
                    ack[owner] = 1'b1;
                    err        = 1'b1;
                    state_nx   = ARB_IDLE;
                end else if (!l_we) begin
                    ack[owner] = 1'b1;
                    rdata      = mem_rdata & size_mask(l_size);
                    state_nx   = ARB_IDLE;
                end else begin
                    // The RAM word starts at the byte address, so new bytes land low.
                    if (l_size == SZ_BYTE) merge_val = {mem_rdata[31:8], l_wdata[7:0]};
                    else if (l_size == SZ_HALF) merge_val = {mem_rdata[31:16], l_wdata[15:0]};
                    state_nx = ARB_WRITE;
                end
            end
            ARB_WRITE: begin
                mem_addr   = l_addr & ADDR_MASK;
                mem_wdata  = merged;
                mem_we     = 1'b1;
                ack[owner] = 1'b1;
                state_nx   = ARB_IDLE;
            end
            default: state_nx = ARB_IDLE;
        endcase
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_dpram_port_arbiter.sv
// Bench for dpram_port_arbiter: per-requester command queues drive the DUT, a
// transaction-level model predicts each ack and RAM write, and a monitor checks them.
module tb_dpram_port_arbiter;
    import dpram_arb_pkg::*;

    localparam int NREQ   = 3;
    localparam int ADDR_W = 16;
    localparam int MEM_B  = 1 << ADDR_W;
    localparam int EXP_W  = 70;   // {cycle[69:38], id[37:34], err[33], chk_rd[32], rdata[31:0]}
    localparam int WR_W   = 96;   // {cycle[95:64], addr[63:32], data[31:0]}
    localparam int TXN_W  = 71;   // {we[70], size[69:68], addr[67:36], wdata[35:4], gap[3:0]}

    // ---------------- clock / reset / DUT ----------------
    logic               m_clock = 1'b0;
    logic               p_reset = 1'b1;
    logic [NREQ-1:0]    req = '0, req_we = '0;
    logic [2*NREQ-1:0]  req_size = '0;
    logic [32*NREQ-1:0] req_addr = '0, req_wdata = '0;
    logic [NREQ-1:0]    ack;
    logic [31:0]        rdata, mem_addr, mem_wdata, mem_rdata;
    logic               err, mem_we;
    arb_state_t         dbg_state;

    always #5 m_clock = ~m_clock;

    dpram_port_arbiter #(.NREQ(NREQ), .ADDR_W(ADDR_W)) dut (
        .m_clock(m_clock), .p_reset(p_reset), .req(req), .req_we(req_we),
        .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
        .ack(ack), .rdata(rdata), .err(err), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
        .dbg_state(dbg_state)
    );

    // RAM stub: byte-addressed, 4 bytes little-endian from mem_addr, wrapping.
    logic [7:0]  ram [MEM_B];
    logic [15:0] ma;
    assign ma = mem_addr[15:0];
    assign mem_rdata = {ram[ma + 16'd3], ram[ma + 16'd2], ram[ma + 16'd1], ram[ma]};
    always @(posedge m_clock) begin
        if (mem_we) begin
            ram[ma]         <= mem_wdata[7:0];
            ram[ma + 16'd1] <= mem_wdata[15:8];
            ram[ma + 16'd2] <= mem_wdata[23:16];
            ram[ma + 16'd3] <= mem_wdata[31:24];
        end
    end

    int cyc = 0;
    always @(posedge m_clock) cyc <= cyc + 1;

    // ---------------- bookkeeping ----------------
    int checks = 0;
    int errors = 0;
    logic [EXP_W-1:0] exp_q[$];
    logic [WR_W-1:0]  wr_q[$];
    logic [TXN_W-1:0] txn_q [NREQ][$];
    int               grant_log[$];
    int               ack_cnt [NREQ];
    int               seen_ack[NREQ];
    logic             busy    [NREQ];
    int               gap_left[NREQ];
    int               we_cnt = 0;
    logic [31:0]      last_rdata = '0;

    // Reference model state
    logic [7:0]  ref_mem [MEM_B];
    int          rr_m = 0;
    int          free_at = 0;
    logic        pend_valid = 1'b0;
    int          pend_cycle = 0;
    logic [15:0] pend_addr = '0;
    logic [31:0] pend_data = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_txn(input int r, input logic we, input logic [1:0] sz,
                            input logic [31:0] a, input logic [31:0] wd, input logic [3:0] gap);
        txn_q[r].push_back({we, sz, a, wd, gap});
    endtask

    function automatic logic [31:0] ref_word(input logic [15:0] a);
        return {ref_mem[a + 16'd3], ref_mem[a + 16'd2], ref_mem[a + 16'd1], ref_mem[a]};
    endfunction

    function automatic logic drained();
        logic d;
        d = (exp_q.size() == 0) && (wr_q.size() == 0);
        for (int i = 0; i < NREQ; i++)
            if (busy[i] || txn_q[i].size() != 0) d = 1'b0;
        return d;
    endfunction

    task automatic wait_idle(input string name, input int budget);
        int k;
        k = 0;
        while (!drained() && k < budget) begin
            @(posedge m_clock);
            k++;
        end
        checks++;
        if (!drained()) begin
            errors++;
            $display("FAIL %s_timeout: traffic still pending after %0d cycles, expected drained", name, budget);
        end
        repeat (2) @(posedge m_clock);
        #1;
    endtask

    // ---------------- driver ----------------
    initial begin : driver
        logic [TXN_W-1:0] t;
        for (int i = 0; i < NREQ; i++) begin
            busy[i] = 1'b0; gap_left[i] = 0; seen_ack[i] = 0;
        end
        forever begin
            @(posedge m_clock);
            #2;
            for (int i = 0; i < NREQ; i++) begin
                if (p_reset) begin
                    req[i] = 1'b0; busy[i] = 1'b0; gap_left[i] = 0; seen_ack[i] = ack_cnt[i];
                end else begin
                    if (busy[i] && ack_cnt[i] != seen_ack[i]) begin
                        seen_ack[i] = ack_cnt[i]; busy[i] = 1'b0; req[i] = 1'b0;
                    end
                    if (!busy[i]) begin
                        if (gap_left[i] != 0) gap_left[i]--;
                        else if (txn_q[i].size() != 0) begin
                            t = txn_q[i].pop_front();
                            req_we[i]            = t[70];
                            req_size[2*i +: 2]   = t[69:68];
                            req_addr[32*i +: 32] = t[67:36];
                            req_wdata[32*i +: 32]= t[35:4];
                            gap_left[i]          = int'(t[3:0]);
                            req[i]               = 1'b1;
                            busy[i]              = 1'b1;
                        end
                    end
                end
            end
        end
    end

    // ---------------- monitor + reference model ----------------
    always @(negedge m_clock) begin : mon
        logic [EXP_W-1:0] e;
        logic [WR_W-1:0]  w;
        logic [NREQ-1:0]  onehot;
        logic [1:0]       sz;
        logic [31:0]      a, wd, cur, nw;
        logic             we, bad;
        int               win, nb;
        if (p_reset) begin
            exp_q.delete(); wr_q.delete(); pend_valid = 1'b0; rr_m = 0; free_at = cyc + 1;
        end else begin
            if (err && ack == '0) check("err_without_ack", 64'(err), 64'(0));
            if (ack != '0) begin
                for (int i = 0; i < NREQ; i++) if (ack[i]) ack_cnt[i]++;
                last_rdata = rdata;
                if (exp_q.size() == 0) begin
                    check("ack_unexpected", 64'(ack), 64'(0));
                end else begin
                    e = exp_q.pop_front();
                    onehot = '0;
                    onehot[e[37:34]] = 1'b1;
                    check("ack_cycle", 64'(cyc), 64'(e[69:38]));
                    check("ack_owner", 64'(ack), 64'(onehot));
                    check("ack_err", 64'(err), 64'(e[33]));
                    if (e[32]) check("rdata", 64'(rdata), 64'(e[31:0]));
                    grant_log.push_back(int'(e[37:34]));
                end
            end else if (exp_q.size() != 0 && int'(exp_q[0][69:38]) < cyc) begin
                e = exp_q.pop_front();
                check("ack_missing", 64'(cyc), 64'(e[69:38]));
            end
            if (mem_we) begin
                we_cnt++;
                if (wr_q.size() == 0) begin
                    check("mem_we_unexpected", 64'(mem_we), 64'(0));
                end else begin
                    w = wr_q.pop_front();
                    check("wr_cycle", 64'(cyc), 64'(w[95:64]));
                    check("wr_addr", 64'(mem_addr), 64'(w[63:32]));
                    check("wr_data", 64'(mem_wdata), 64'(w[31:0]));
                end
            end else if (wr_q.size() != 0 && int'(wr_q[0][95:64]) < cyc) begin
                w = wr_q.pop_front();
                check("wr_missing", 64'(cyc), 64'(w[95:64]));
            end
            if (pend_valid && pend_cycle == cyc) begin
                for (int k = 0; k < 4; k++) ref_mem[pend_addr + 16'(k)] = pend_data[8*k +: 8];
                pend_valid = 1'b0;
            end
            // Model: a free sequencer with pending requests grants the nearest from rr_m.
            if (cyc >= free_at && req != '0) begin
                win = -1;
                for (int k = 0; k < NREQ; k++)
                    if (win < 0 && req[(rr_m + k) % NREQ]) win = (rr_m + k) % NREQ;
                we  = req_we[win];
                sz  = req_size[2*win +: 2];
                a   = req_addr[32*win +: 32];
                wd  = req_wdata[32*win +: 32];
                nb  = (sz == SZ_BYTE) ? 1 : (sz == SZ_HALF) ? 2 : 4;
                bad = (sz == SZ_RSVD) || (64'(a) + 64'(nb) > 64'(MEM_B));
                rr_m = (win + 1) % NREQ;
                if (bad) begin
                    exp_q.push_back({32'(cyc + 1), 4'(win), 1'b1, 1'b0, 32'd0});
                    free_at = cyc + 2;
                end else if (!we) begin
                    cur = ref_word(a[15:0]);
                    if (nb < 4) cur = cur & ((32'd1 << (8 * nb)) - 32'd1);
                    exp_q.push_back({32'(cyc + 1), 4'(win), 1'b0, 1'b1, cur});
                    free_at = cyc + 2;
                end else begin
                    nw = ref_word(a[15:0]);
                    for (int k = 0; k < nb; k++) nw[8*k +: 8] = wd[8*k +: 8];
                    wr_q.push_back({32'(cyc + 2), a, nw});
                    exp_q.push_back({32'(cyc + 2), 4'(win), 1'b0, 1'b0, 32'd0});
                    pend_valid = 1'b1; pend_cycle = cyc + 2; pend_addr = a[15:0]; pend_data = nw;
                    free_at = cyc + 3;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin : main
        logic [7:0]  v;
        int          we_base, glog_base, k;
        int          r, cls, szr;
        logic [31:0] a;
        for (int i = 0; i < NREQ; i++) ack_cnt[i] = 0;
        for (int i = 0; i < MEM_B; i++) begin
            v = 8'($urandom);
            ram[i] <= v;
            ref_mem[i] = v;
        end
        repeat (3) @(posedge m_clock);
        #1;
        check("rst_ack", 64'(ack), 64'(0));
        check("rst_err", 64'(err), 64'(0));
        check("rst_rdata", 64'(rdata), 64'(0));
        check("rst_mem_we", 64'(mem_we), 64'(0));
        check("rst_mem_addr", 64'(mem_addr), 64'(0));
        check("rst_mem_wdata", 64'(mem_wdata), 64'(0));
        check("rst_state", 64'(dbg_state), 64'(ARB_IDLE));
        p_reset = 1'b0;

        // Word write then byte read of the same word.
        push_txn(0, 1'b1, SZ_WORD, 32'h0100, 32'h1122_3344, 4'd0);
        push_txn(0, 1'b0, SZ_BYTE, 32'h0102, 32'h0, 4'd0);
        wait_idle("word_then_byte", 200);
        check("byte_read_value", 64'(last_rdata), 64'h22);

        // Halfword read-modify-write at an odd address.
        we_base = we_cnt;
        push_txn(0, 1'b1, SZ_WORD, 32'h0100, 32'hAABB_CCDD, 4'd0);
        push_txn(0, 1'b1, SZ_HALF, 32'h0101, 32'h0000_BEEF, 4'd0);
        push_txn(0, 1'b0, SZ_WORD, 32'h0100, 32'h0, 4'd0);
        wait_idle("half_rmw", 200);
        check("half_rmw_value", 64'(last_rdata), 64'hAABE_EFDD);
        check("half_rmw_we_cycles", 64'(we_cnt - we_base), 64'd2);

        // Three requesters contending with back-to-back reads.
        for (int i = 0; i < NREQ; i++)
            for (int n = 0; n < 4; n++)
                push_txn(i, 1'b0, SZ_WORD, 32'h0200 + 32'(4 * i), 32'h0, 4'd0);
        wait_idle("contention", 400);

        // Window boundaries and rejected accesses.
        we_base = we_cnt;
        push_txn(1, 1'b0, SZ_WORD, 32'h0000_FFFD, 32'h0, 4'd0);
        push_txn(1, 1'b1, SZ_RSVD, 32'h0000_0300, 32'hDEAD_BEEF, 4'd0);
        push_txn(2, 1'b1, SZ_BYTE, 32'h0000_FFFF, 32'h0000_005A, 4'd0);
        push_txn(2, 1'b0, SZ_WORD, 32'h0000_FFFC, 32'h0, 4'd0);
        push_txn(0, 1'b1, SZ_HALF, 32'h0000_FFFF, 32'h0000_1234, 4'd0);
        push_txn(0, 1'b1, SZ_WORD, 32'h8000_0000, 32'h0BAD_0BAD, 4'd0);
        wait_idle("boundary", 400);
        check("boundary_we_cycles", 64'(we_cnt - we_base), 64'd1);

        // Reset while a byte write from requester 1 sits in READ.
        we_base = we_cnt;
        push_txn(1, 1'b1, SZ_BYTE, 32'h0000_0300, 32'h0000_0077, 4'd0);
        k = 0;
        while (exp_q.size() == 0 && k < 50) begin
            @(negedge m_clock);
            #1;
            k++;
        end
        check("reset_grant_seen", 64'(exp_q.size() != 0), 64'd1);
        @(posedge m_clock);
        #1;
        p_reset = 1'b1;
        @(posedge m_clock);
        #1;
        p_reset = 1'b0;
        check("post_rst_ack", 64'(ack), 64'(0));
        check("post_rst_mem_we", 64'(mem_we), 64'(0));
        check("post_rst_mem_addr", 64'(mem_addr), 64'(0));
        check("post_rst_mem_wdata", 64'(mem_wdata), 64'(0));
        check("post_rst_state", 64'(dbg_state), 64'(ARB_IDLE));
        glog_base = grant_log.size();
        push_txn(2, 1'b0, SZ_WORD, 32'h0000_0300, 32'h0, 4'd0);
        push_txn(0, 1'b0, SZ_WORD, 32'h0000_0300, 32'h0, 4'd0);
        wait_idle("after_reset", 200);
        check("post_rst_first_grant", 64'((grant_log.size() > glog_base) ? grant_log[glog_base] : -1), 64'd0);
        check("reset_abandon_we", 64'(we_cnt - we_base), 64'd0);

        // Randomized mixed traffic.
        for (int n = 0; n < 150; n++) begin
            r   = $urandom_range(0, NREQ - 1);
            cls = $urandom_range(0, 9);
            szr = $urandom_range(0, 9);
            if (cls < 7) a = 32'($urandom_range(0, 255));
            else if (cls < 9) a = 32'($urandom_range(16'hFFF0, 16'hFFFF));
            else a = $urandom;
            push_txn(r, 1'($urandom_range(0, 1)),
                     (szr < 3) ? SZ_BYTE : (szr < 6) ? SZ_HALF : (szr < 9) ? SZ_WORD : SZ_RSVD,
                     a, $urandom, 4'($urandom_range(0, 3)));
        end
        wait_idle("random", 5000);

        k = 0;
        for (int i = 0; i < MEM_B; i++) if (ram[i] !== ref_mem[i]) k++;
        check("ram_contents_diff", 64'(k), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dpram_port_arbiter.md
# dpram_port_arbiter

Round-robin arbiter and sequencer that shares one port of the byte-addressed 32-bit dual-port RAM (`dpram`) between NREQ requesters. It accepts byte, halfword and word reads and writes. The RAM port only writes full words, so sub-word writes are performed as read-modify-write. Addresses outside the RAM window are rejected with an error flag. One instance sits in front of each RAM port; for example, port 1 serves fetch/debug and port 2 serves load-store/DMA.

## Interface
- NREQ, 3, number of requesters (2..8)
- ADDR_W, 16, RAM byte-address width; the RAM holds 2^ADDR_W bytes
- m_clock  in  1  clock; all logic on rising edge
- p_reset  in  1  synchronous, active-high reset
- req  in  NREQ  per-requester request; held high until its ack
- req_we  in  NREQ  1 = write, 0 = read
- req_size  in  2*NREQ  per-requester size: 0 = byte, 1 = half, 2 = word, 3 = reserved (treated as error)
- req_addr  in  32*NREQ  per-requester byte address, little-endian, any alignment
- req_wdata  in  32*NREQ  per-requester write data, low bytes significant
- ack  out  NREQ  one-cycle completion pulse to the granted requester
- rdata  out  32  read data, zero-extended; valid only in the ack cycle
- err  out  1  high with ack when the access was rejected
- mem_addr  out  32  to RAM addr; upper bits zero
- mem_wdata  out  32  to RAM wdata
- mem_we  out  1  to RAM we
- mem_rdata  in  32  from RAM rdata; combinational read of the current mem_addr

## Operation
- States: IDLE, READ, WRITE.
- **IDLE**
  - If any req is high, grant the first set bit at or after rr_ptr, scanning with wrap.
  - Latch the winner's we, size, addr and wdata, then go to READ.
  - rr_ptr becomes (grant+1) mod NREQ.
- **Range check (in IDLE)**
  - A request is bad if size = 3 or addr + bytes(size) > 2^ADDR_W.
  - A bad request still goes to READ. There it drives ack and err, and mem_we stays 0.
- **READ** (mem_addr = latched addr, mem_we = 0)
  - Read: pulse ack. rdata = mem_rdata masked to 8/16/32 bits by size. Go to IDLE.
  - Word write: skip the merge, go straight to WRITE.
  - Sub-word write: merge into a register. Byte gives {mem_rdata[31:8], wdata[7:0]}; half gives {mem_rdata[31:16], wdata[15:0]}. Go to WRITE.
- **WRITE**
  - Drive mem_addr = latched addr, mem_wdata = merged value (or wdata for word), mem_we = 1.
  - Pulse ack with err = 0, go to IDLE.
- **Ownership**
  - Only the granted requester's ack ever pulses.
  - Requests from other requesters stay pending; nothing is dropped.
  - If the granted requester deasserts req before its ack, the latched operation still completes and acks.
- **Reset values**
  - state = IDLE, rr_ptr = 0, ack = 0, err = 0, rdata = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0.
  - Reset mid-operation abandons it: no write is issued, no ack.

## Timing
- Request seen in IDLE at cycle T:
  - read: ack in T+1
  - word write: RAM write at the clock edge ending T+2, ack in T+2
  - sub-word write: also ack in T+2, with a RAM read in T+1
- Error: ack and err in T+1.
- Throughput: one access per 2 cycles (read or error) or 3 cycles (write), since IDLE always takes one cycle.
- A requester that keeps req high after its ack is re-arbitrated in the next IDLE. Under contention it waits at most NREQ-1 grants.
- mem_we is high only in WRITE. mem_addr is held constant from READ through WRITE.
- Simultaneous RAM-port conflicts (both ports writing overlapping bytes) are the integrator's responsibility and are not detected here.

## Structure
- Package `dpram_arb_pkg`:
  - size encoding constants SZ_BYTE, SZ_HALF, SZ_WORD
  - state enum ARB_IDLE, ARB_READ, ARB_WRITE
  - function bytes_of(size)
- Sub-module `rr_arbiter`:
  - combinational first-set-bit-from-pointer grant over NREQ
  - the rr_ptr register stays in the parent

## Test plan
- Single requester 0 writes word 0x11223344 at 0x0100, then reads a byte at 0x0102.
  - Required: ack at T+2 for the write and T+1 for the read; rdata = 0x00000022.
- Halfword write 0xBEEF at 0x0101 over a word preloaded 0xAABBCCDD at 0x0100.
  - Required: the word at 0x0100 reads back 0xAABEEFDD; mem_we is high for exactly 1 cycle.
- Requesters 0, 1 and 2 all hold req with reads.
  - Required: grants 0, 1, 2, 0, ... with acks 2 cycles apart, and no ack to a non-granted requester.
- Word read at 0xFFFD with ADDR_W = 16, and a request with size = 3.
  - Required: ack and err in T+1, mem_we never asserted, RAM contents unchanged.
- p_reset asserted in READ of a byte write.
  - Required: no mem_we pulse, no ack, all outputs 0 the next cycle; the next grant goes to requester 0.
